// File: rtl/apb_slave_regbank_if.sv
// APB3 bus bundle between a requester (master) and the register bank (slave).
interface apb_slave_regbank_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_regbank.sv
// APB3 register bank with programmable wait states, pslverr on bad address and a saturating error count.
// Latency: WAIT+2 cycles per transfer; backpressure is pready held low for WAIT access cycles.
module apb_slave_regbank #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [3:0]            WAIT_RST   = 4'd0
) (
  input  logic                 pclock,
  input  logic                 preset,
  apb_slave_regbank_if.slave   bus,
  output logic [7:0]           err_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-3:0] WAIT_WORD = (ADDR_WIDTH-2)'(DEPTH);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt;
  logic [3:0]            wait_reg;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  lat_write, lat_err, lat_wait;
  logic [IDX_W-1:0]      lat_idx;

  logic                  pready_q, pslverr_q;
  logic [DATA_WIDTH-1:0] prdata_q;

  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-3:0] word;
  logic                  dec_err, dec_wait;
  logic [IDX_W-1:0]      dec_idx;

  logic                  do_setup, do_tick, do_ready, do_done, do_clear, set_ready;
  logic                  rsp_err, rsp_wait, rsp_write;
  logic [IDX_W-1:0]      rsp_idx;
  logic [DATA_WIDTH-1:0] rsp_data;

  // Addresses below BASE_ADDR wrap to huge offsets and decode as out of range.
  assign offset   = bus.paddr - BASE_ADDR;
  assign word     = offset[ADDR_WIDTH-1:2];
  assign dec_wait = (word == WAIT_WORD);
  assign dec_err  = (offset[1:0] != 2'b00) || (word > WAIT_WORD);
  assign dec_idx  = word[IDX_W-1:0];

  always_comb begin
    state_nxt = state;
    do_setup  = 1'b0;
    do_tick   = 1'b0;
    do_ready  = 1'b0;
    do_done   = 1'b0;
    do_clear  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.psel && !bus.penable) begin
          do_setup  = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (!bus.psel) begin
          do_clear  = 1'b1;
          state_nxt = IDLE;
        end else if (!pready_q) begin
          do_tick  = 1'b1;
          do_ready = (cnt == 4'd1);
        end else if (bus.penable) begin
          do_done   = 1'b1;
          do_clear  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Zero-wait responses come straight from the decode; delayed ones from the latched setup.
  always_comb begin
    set_ready = (do_setup && (wait_reg == 4'd0)) || do_ready;
    rsp_err   = do_setup ? dec_err     : lat_err;
    rsp_wait  = do_setup ? dec_wait    : lat_wait;
    rsp_write = do_setup ? bus.pwrite  : lat_write;
    rsp_idx   = do_setup ? dec_idx     : lat_idx;
    rsp_data  = '0;
    if (!rsp_write && !rsp_err)
      rsp_data = rsp_wait ? DATA_WIDTH'(wait_reg) : mem[rsp_idx];
  end

  always_ff @(posedge pclock) begin
    if (preset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge pclock) begin
    if (preset) begin
      cnt       <= 4'd0;
      wait_reg  <= WAIT_RST;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      lat_wait  <= 1'b0;
      lat_idx   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      err_count <= 8'd0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_setup) begin
        lat_write <= bus.pwrite;
        lat_err   <= dec_err;
        lat_wait  <= dec_wait;
        lat_idx   <= dec_idx;
        cnt       <= wait_reg;
      end
      if (do_tick) cnt <= cnt - 4'd1;
      if (set_ready) begin
        pready_q  <= 1'b1;
        pslverr_q <= rsp_err;
        prdata_q  <= rsp_data;
        if (rsp_err && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
      end
      if (do_done && lat_write && !lat_err) begin
        if (lat_wait) wait_reg     <= bus.pwdata[3:0];
        else          mem[lat_idx] <= bus.pwdata;
      end
      if (do_clear) begin
        pready_q  <= 1'b0;
        pslverr_q <= 1'b0;
        prdata_q  <= '0;
      end
    end
  end

  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;
  assign bus.prdata  = prdata_q;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Randomized APB bench for apb_slave_regbank: an address-map model predicts every output every cycle.
module tb_apb_slave_regbank;

  localparam int          AW       = 32;
  localparam int          DW       = 32;
  localparam int          DEPTH    = 16;
  localparam logic [31:0] BASE     = 32'h0000_0000;
  localparam logic [3:0]  WAIT_RST = 4'd0;
  localparam logic [31:0] WAIT_OFF = 32'(4 * DEPTH);

  logic       clk = 1'b0;
  logic       preset = 1'b1;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  apb_slave_regbank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_slave_regbank #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
    .BASE_ADDR(BASE), .WAIT_RST(WAIT_RST)
  ) dut (
    .pclock(clk), .preset(preset), .bus(bus), .err_count(err_count)
  );

  // Reference model: architectural register contents only.
  logic [31:0] mem_m [DEPTH];
  logic [3:0]  wait_m;
  logic [7:0]  errcnt_m;

  logic        chk_en = 1'b0;
  logic        exp_pready, exp_pslverr;
  logic [31:0] exp_prdata;
  logic [7:0]  exp_err;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pready",    {31'b0, bus.pready},  {31'b0, exp_pready});
      chk("pslverr",   {31'b0, bus.pslverr}, {31'b0, exp_pslverr});
      chk("prdata",    bus.prdata,           exp_prdata);
      chk("err_count", {24'b0, err_count},   {24'b0, exp_err});
    end
  end

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic e);
    return (e && v != 8'hFF) ? v + 8'd1 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'd0;
    wait_m   = WAIT_RST;
    errcnt_m = 8'd0;
  endtask

  task automatic set_idle_exp();
    exp_pready  = 1'b0;
    exp_pslverr = 1'b0;
    exp_prdata  = 32'd0;
    exp_err     = errcnt_m;
  endtask

  task automatic bus_idle();
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = $urandom;
    bus.pwdata  = $urandom;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus_idle();
      set_idle_exp();
      @(posedge clk); #1;
    end
  endtask

  // One APB transfer, entered and left at posedge+1. abort_at/rst_at name the access
  // cycle (1-based) in which psel is dropped / preset is raised; 0 disables.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input int abort_at, input int rst_at,
                      output logic [31:0] rd_o, output logic err_o, output int cyc_o);
    logic [31:0] off, rexp;
    logic        err, rdy;
    int          n, cyc;
    off   = addr - BASE;
    err   = (addr[1:0] != 2'b00) || (off > WAIT_OFF);
    n     = int'(wait_m);
    rexp  = 32'd0;
    if (!err) rexp = (off == WAIT_OFF) ? {28'd0, wait_m} : mem_m[off >> 2];
    rd_o  = 32'd0;
    err_o = 1'b0;
    cyc_o = 0;
    cyc   = 0;

    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = wr;
    bus.paddr   = addr;
    bus.pwdata  = $urandom;
    set_idle_exp();
    @(negedge clk); cyc++;
    @(posedge clk); #1;

    for (int k = 1; k <= n + 1; k++) begin
      rdy         = (k == n + 1);
      bus.penable = 1'b1;
      bus.pwrite  = $urandom_range(0, 1);
      bus.paddr   = $urandom;
      bus.pwdata  = rdy ? data : $urandom;
      if (k == abort_at) bus.psel = 1'b0;
      if (k == rst_at) preset = 1'b1;
      exp_pready  = rdy;
      exp_pslverr = rdy && err;
      exp_prdata  = (rdy && !wr && !err) ? rexp : 32'd0;
      exp_err     = sat_inc(errcnt_m, rdy && err);
      @(negedge clk); cyc++;
      if (bus.pready === 1'b1) begin
        rd_o  = bus.prdata;
        err_o = bus.pslverr;
        cyc_o = cyc;
      end
      @(posedge clk); #1;
      if (k == abort_at) begin
        bus_idle();
        set_idle_exp();
        return;
      end
      if (k == rst_at) begin
        model_reset();
        preset = 1'b0;
        bus_idle();
        set_idle_exp();
        return;
      end
    end

    errcnt_m = sat_inc(errcnt_m, err);
    if (wr && !err) begin
      if (off == WAIT_OFF) wait_m = data[3:0];
      else                 mem_m[off >> 2] = data;
    end
    bus_idle();
    set_idle_exp();
  endtask

  function automatic logic [31:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 6)      return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
    else if (r == 7) return BASE + WAIT_OFF;
    else if (r == 8) return BASE + 32'(4 * $urandom_range(0, DEPTH)) + 32'($urandom_range(1, 3));
    else             return BASE + WAIT_OFF + 32'(4 * $urandom_range(1, 1000));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        e;
    int          cyc;

    bus_idle();
    model_reset();
    set_idle_exp();
    preset = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    preset = 1'b0;

    // Reset then read word 3.
    xfer(1'b0, BASE + 32'h0C, 32'd0, 0, 0, rd, e, cyc);
    chk("rst_read_cycles", cyc, 2);
    chk("rst_read_data", rd, 32'd0);
    chk("rst_read_err", {31'b0, e}, 32'd0);

    // Zero-wait write/read.
    xfer(1'b1, BASE + 32'h08, 32'hDEAD_BEEF, 0, 0, rd, e, cyc);
    chk("wr8_cycles", cyc, 2);
    xfer(1'b0, BASE + 32'h08, 32'd0, 0, 0, rd, e, cyc);
    chk("rd8_cycles", cyc, 2);
    chk("rd8_data", rd, 32'hDEAD_BEEF);

    // Wait states.
    xfer(1'b1, BASE + 32'h40, 32'd3, 0, 0, rd, e, cyc);
    xfer(1'b0, BASE + 32'h04, 32'd0, 0, 0, rd, e, cyc);
    chk("wait3_cycles", cyc, 5);

    // Errors.
    xfer(1'b0, BASE + 32'h44, 32'd0, 0, 0, rd, e, cyc);
    chk("oor_err", {31'b0, e}, 32'd1);
    chk("oor_data", rd, 32'd0);
    chk("oor_count", {24'b0, err_count}, 32'd1);
    xfer(1'b1, BASE + 32'h06, 32'hFFFF_FFFF, 0, 0, rd, e, cyc);
    chk("mis_err", {31'b0, e}, 32'd1);
    chk("mis_count", {24'b0, err_count}, 32'd2);
    xfer(1'b0, BASE + 32'h04, 32'd0, 0, 0, rd, e, cyc);
    chk("mis_nowrite", rd, 32'd0);

    // Abort with WAIT=5.
    xfer(1'b1, BASE + 32'h40, 32'd5, 0, 0, rd, e, cyc);
    xfer(1'b1, BASE + 32'h00, 32'h1111_1111, 0, 0, rd, e, cyc);
    chk("wait5_cycles", cyc, 7);
    xfer(1'b1, BASE + 32'h00, 32'h2222_2222, 2, 0, rd, e, cyc);
    xfer(1'b0, BASE + 32'h00, 32'd0, 0, 0, rd, e, cyc);
    chk("abort_old_value", rd, 32'h1111_1111);

    // Reset mid-wait.
    xfer(1'b1, BASE + 32'h00, 32'h3333_3333, 0, 3, rd, e, cyc);
    chk("midrst_count", {24'b0, err_count}, 32'd0);
    xfer(1'b0, BASE + 32'h40, 32'd0, 0, 0, rd, e, cyc);
    chk("midrst_wait", rd, {28'd0, WAIT_RST});
    chk("midrst_cycles", cyc, 2);
    xfer(1'b0, BASE + 32'h00, 32'd0, 0, 0, rd, e, cyc);
    chk("midrst_word0", rd, 32'd0);

    // Randomized traffic, with occasional idle gaps and aborts.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic        w;
      int          ab;
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
      a  = pick_addr();
      w  = 1'($urandom_range(0, 1));
      ab = 0;
      if (wait_m != 4'd0 && $urandom_range(0, 9) == 0) ab = $urandom_range(1, int'(wait_m));
      xfer(w, a, $urandom, ab, 0, rd, e, cyc);
    end

    // Saturation.
    xfer(1'b1, BASE + 32'h40, 32'd0, 0, 0, rd, e, cyc);
    for (int i = 0; i < 300; i++)
      xfer(1'($urandom_range(0, 1)), (i % 2 == 0) ? BASE + 32'h44 : BASE + 32'h06, $urandom, 0, 0, rd, e, cyc);
    chk("sat_count", {24'b0, err_count}, 32'h0000_00FF);

    idle_cycles(2);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_slave_regbank.md
# apb_slave_regbank

APB3 completer sitting directly downstream of the APB master: consumes its `psel`/`penable`/`pwrite`/`paddr`/`pwdata` and returns `prdata`/`pready`/`pslverr`. It holds a bank of word-addressed read/write registers plus one control register that sets a run-time-programmable number of wait states. It flags out-of-range and misaligned accesses with `pslverr`, and keeps a saturating error counter. It is the default target for exercising the master's ready/error handling in the UVM bench.

## Interface
- `ADDR_WIDTH`, 32: width of `paddr`.
- `DATA_WIDTH`, 32: width of `pwdata`/`prdata`.
- `DEPTH`, 16: number of storage words, at least 2.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0. Must be word aligned.
- `WAIT_RST`, 4'd0: reset value of the wait-state register.
- `pclock` in 1: APB clock. All logic is on the rising edge.
- `preset` in 1: reset. Synchronous and active-high.
- `psel` in 1: completer select.
- `penable` in 1: access phase.
- `pwrite` in 1: 1 = write, 0 = read.
- `paddr` in ADDR_WIDTH: byte address.
- `pwdata` in DATA_WIDTH: write data.
- `prdata` out DATA_WIDTH: read data. Registered.
- `pready` out 1: transfer completes this cycle. Registered.
- `pslverr` out 1: error response. Valid only when `pready` is high. Registered.
- `err_count` out 8: saturating count of error responses.

## Operation
- **Register map** (offset = `paddr - BASE_ADDR`):
  - Offsets 0 to 4*(DEPTH-1): storage words, read/write.
  - Offset 4*DEPTH: WAIT register. Bits [3:0] are read/write; reads return zero-extended.
  - Anything else is out of range.
- **Error conditions:** out-of-range address, or `paddr[1:0]` != 0.
  - The transfer still completes after the wait states, with `pslverr`=1 and `prdata`=0.
  - Nothing is written.
  - `err_count` increments and saturates at 8'hFF.
- **FSM states:** IDLE, ACCESS.
- **IDLE:**
  - When `psel`=1 and `penable`=0 (setup phase): latch the address, direction and decode/error result; load `cnt` = WAIT[3:0]; go to ACCESS.
  - If `cnt` loads as 0, set `pready`=1 in the same edge.
  - For a read, load `prdata` at the same edge `pready` is set.
- **ACCESS while `pready`=0:**
  - Decrement `cnt`.
  - On the edge where `cnt` goes from 1 to 0, set `pready`=1 and load `prdata`/`pslverr`.
- **ACCESS while `pready`=1, `psel`=1 and `penable`=1:** the transfer completes.
  - A write commits `pwdata` to the target at this edge. A WAIT write takes `pwdata[3:0]`.
  - Clear `pready`, `pslverr` and `prdata`; return to IDLE.
- **Abort:** if `psel` is 0 in ACCESS, return to IDLE without writing and clear the outputs. This is a master protocol violation; the block only recovers from it.
- **`pwrite`/`paddr` changing during ACCESS:** ignored. The latched setup values are used.
- **Write data:** taken from `pwdata` at the completion edge, not at setup.
- **A new WAIT value** applies from the next transfer's setup phase.

## Timing
- **Reset (`preset`=1 at a clock edge):**
  - `prdata`=0, `pready`=0, `pslverr`=0, `err_count`=0.
  - All storage words = 0; WAIT = `WAIT_RST`; FSM = IDLE; `cnt`=0.
  - Reset asserted mid-transfer aborts it with no write.
- **Latency:** with WAIT=N, `pready` rises in access cycle N+1.
  - N=0 gives the minimum 2-cycle APB transfer (setup, access).
  - The total transfer is N+2 cycles.
- **Back-to-back transfers:** the master may drive the next setup phase in the cycle after completion. IDLE accepts it immediately, so there are no dead cycles.
- **`pready` width:** high for exactly one cycle per transfer.
- **`pslverr`:** never high while `pready` is low.
- **Read-after-write** to the same word returns the new data. The write commits at completion, before the next setup.

## Test plan
- **Reset then read:** reset, WAIT=0; read word 3 -> `pready` high in the first access cycle, `prdata`=0, `pslverr`=0.
- **Write/read, zero wait:** write 32'hDEAD_BEEF to offset 0x8, then read 0x8 -> 2 cycles each, read returns 32'hDEAD_BEEF, no error.
- **Wait states:** write 4'd3 to offset 0x40 (DEPTH=16), then read offset 0x4 -> `pready` low for 3 access cycles, high in the 4th; the transfer takes 5 cycles.
- **Errors:**
  - Read 0x44 -> `pslverr`=1 with `pready`, `prdata`=0, `err_count`=1.
  - Write 0x6 -> `pslverr`=1, storage unchanged, `err_count`=2.
  - 300 error transfers -> `err_count`=8'hFF.
- **Abort and reset:**
  - With WAIT=5, drop `psel` in access cycle 2 of a write to 0x0 -> no write, next read of 0x0 returns the old value.
  - Assert `preset` mid-wait -> all outputs 0 next cycle, WAIT back to `WAIT_RST`.
